// File: rtl/id_operand_fetch.sv
// id_operand_fetch: MIPS ID stage - decode, operand read, RAW stall, ID/EX reg.
// Optional `ID_OPERAND_FETCH_FWD_EN: MEM-stage results bypass instead of stalling.
// Ports:
//   clk, rst            clock, async active-high reset
//   IF_instruction      instruction from fetch
//   flush               load a bubble, never stall
//   MEM_instruction     instruction in MEM (hazard source)
//   MEM_result          MEM write-back value (forwarding only)
//   t0..t5, s0..s5      architectural registers (written on negedge)
//   ID_instruction/ID_rs_val/ID_rt_val/ID_imm  ID/EX register
//   stall               combinational PC/IF hold
//   stall_cnt           saturating stall-cycle counter
module id_operand_fetch #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      IF_instruction,
    input  logic             flush,
    input  logic [31:0]      MEM_instruction,
    input  logic [31:0]      MEM_result,
    input  logic [31:0]      t0,
    input  logic [31:0]      t1,
    input  logic [31:0]      t2,
    input  logic [31:0]      t3,
    input  logic [31:0]      t4,
    input  logic [31:0]      t5,
    input  logic [31:0]      s0,
    input  logic [31:0]      s1,
    input  logic [31:0]      s2,
    input  logic [31:0]      s3,
    input  logic [31:0]      s4,
    input  logic [31:0]      s5,
    output logic [31:0]      ID_instruction,
    output logic [31:0]      ID_rs_val,
    output logic [31:0]      ID_rt_val,
    output logic [31:0]      ID_imm,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;

    function automatic logic is_arch(input logic [4:0] r);
        return ((r >= 5'd8) && (r <= 5'd13)) ||
               ((r >= 5'd16) && (r <= 5'd21));
    endfunction

    // Unmapped destinations collapse to 0 so they never match.
    function automatic logic [4:0] dest_of(
        input logic [5:0] op,
        input logic [4:0] rt,
        input logic [4:0] rd
    );
        logic [4:0] d;
        d = 5'd0;
        unique case (1'b1)
            (op == OP_R):                     d = rd;
            (op == OP_LW) || (op == OP_ADDI): d = rt;
            default:                          d = 5'd0;
        endcase
        return is_arch(d) ? d : 5'd0;
    endfunction

    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic        use_rs, use_rt;
    logic [4:0]  dst_ex, dst_mem;
    logic [31:0] rs_rd, rt_rd;
    logic        rs_ex, rt_ex, rs_mem, rt_mem;
    logic        hazard_ex, hazard_mem;
    logic [31:0] rs_v, rt_v;

    assign op = IF_instruction[31:26];
    assign rs = IF_instruction[25:21];
    assign rt = IF_instruction[20:16];

    assign use_rs = (op == OP_R) || (op == OP_LW) ||
                    (op == OP_ADDI) || (op == OP_SW) ||
                    (op == OP_BEQ);
    assign use_rt = (op == OP_R) || (op == OP_SW) ||
                    (op == OP_BEQ);

    assign dst_ex  = dest_of(ID_instruction[31:26],
                             ID_instruction[20:16],
                             ID_instruction[15:11]);
    assign dst_mem = dest_of(MEM_instruction[31:26],
                             MEM_instruction[20:16],
                             MEM_instruction[15:11]);

    always_comb begin
        rs_rd = '0;
        rt_rd = '0;
        unique case (rs)
            5'd8:    rs_rd = t0;
            5'd9:    rs_rd = t1;
            5'd10:   rs_rd = t2;
            5'd11:   rs_rd = t3;
            5'd12:   rs_rd = t4;
            5'd13:   rs_rd = t5;
            5'd16:   rs_rd = s0;
            5'd17:   rs_rd = s1;
            5'd18:   rs_rd = s2;
            5'd19:   rs_rd = s3;
            5'd20:   rs_rd = s4;
            5'd21:   rs_rd = s5;
            default: rs_rd = '0;
        endcase
        unique case (rt)
            5'd8:    rt_rd = t0;
            5'd9:    rt_rd = t1;
            5'd10:   rt_rd = t2;
            5'd11:   rt_rd = t3;
            5'd12:   rt_rd = t4;
            5'd13:   rt_rd = t5;
            5'd16:   rt_rd = s0;
            5'd17:   rt_rd = s1;
            5'd18:   rt_rd = s2;
            5'd19:   rt_rd = s3;
            5'd20:   rt_rd = s4;
            5'd21:   rt_rd = s5;
            default: rt_rd = '0;
        endcase
    end

    assign rs_ex  = use_rs && (dst_ex != 5'd0) && (rs == dst_ex);
    assign rt_ex  = use_rt && (dst_ex != 5'd0) && (rt == dst_ex);
    assign rs_mem = use_rs && (dst_mem != 5'd0) && (rs == dst_mem);
    assign rt_mem = use_rt && (dst_mem != 5'd0) && (rt == dst_mem);

    assign hazard_ex  = rs_ex || rt_ex;
    assign hazard_mem = rs_mem || rt_mem;

    logic unused_ok;

`ifdef ID_OPERAND_FETCH_FWD_EN
    assign rs_v  = rs_mem ? MEM_result : rs_rd;
    assign rt_v  = rt_mem ? MEM_result : rt_rd;
    assign stall = !rst && !flush && hazard_ex;
    assign unused_ok = ^{MEM_instruction[25:21],
                         MEM_instruction[10:0]};
`else
    assign rs_v  = rs_rd;
    assign rt_v  = rt_rd;
    assign stall = !rst && !flush &&
                   (hazard_ex || hazard_mem);
    assign unused_ok = ^{MEM_result,
                         MEM_instruction[25:21],
                         MEM_instruction[10:0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ID_instruction <= '0;
            ID_rs_val      <= '0;
            ID_rt_val      <= '0;
            ID_imm         <= '0;
        end else if (flush || stall) begin
            ID_instruction <= '0;
            ID_rs_val      <= '0;
            ID_rt_val      <= '0;
            ID_imm         <= '0;
        end else begin
            ID_instruction <= IF_instruction;
            ID_rs_val      <= rs_v;
            ID_rt_val      <= rt_v;
            ID_imm         <= {{16{IF_instruction[15]}},
                               IF_instruction[15:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_operand_fetch.sv
// tb_id_operand_fetch: scoreboard bench for id_operand_fetch.
// Second instance with CNT_W=4 checks counter saturation.
module tb_id_operand_fetch;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
    } row_t;

    localparam logic [31:0] ADD  = 32'h01095020;
    localparam logic [31:0] ADDI = 32'h2011FFFF;
    localparam logic [31:0] LW   = 32'h8E080004;
    localparam logic [31:0] SW   = 32'hAE0A0000;
    localparam logic [31:0] ADD7 = 32'h01093820;
    localparam logic [31:0] USE7 = 32'h00E95820;
    localparam logic [31:0] ADDD = 32'h01085020;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [31:0] IF_instruction, MEM_instruction, MEM_result;
    logic [31:0] t0, t1, t2, t3, t4, t5;
    logic [31:0] s0, s1, s2, s3, s4, s5;
    logic [31:0] ID_instruction, ID_rs_val, ID_rt_val, ID_imm;
    logic        stall;
    logic [15:0] stall_cnt;
    logic [31:0] b_ins, b_rs, b_rt, b_imm;
    logic        b_stall;
    logic [3:0]  b_cnt;

    int   checks = 0;
    int   failures = 0;
    int   exp_cnt = 0;
    row_t sb[$];
    row_t e;

    always #5 clk = ~clk;

    id_operand_fetch dut (
        .clk(clk), .rst(rst),
        .IF_instruction(IF_instruction), .flush(flush),
        .MEM_instruction(MEM_instruction),
        .MEM_result(MEM_result),
        .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5),
        .ID_instruction(ID_instruction), .ID_rs_val(ID_rs_val),
        .ID_rt_val(ID_rt_val), .ID_imm(ID_imm),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    id_operand_fetch #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .IF_instruction(IF_instruction), .flush(flush),
        .MEM_instruction(MEM_instruction),
        .MEM_result(MEM_result),
        .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5),
        .ID_instruction(b_ins), .ID_rs_val(b_rs),
        .ID_rt_val(b_rt), .ID_imm(b_imm),
        .stall(b_stall), .stall_cnt(b_cnt)
    );

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        IF_instruction = ADD; MEM_instruction = '0;
        MEM_result = 32'hDEAD0001;
        t0 = 32'd5; t1 = 32'd3; t2 = '0; t3 = '0;
        t4 = '0; t5 = '0; s0 = '0; s1 = '0;
        s2 = '0; s3 = '0; s4 = '0; s5 = '0;
        @(posedge clk); #1;
        checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== '0) begin
            failures++;
            $display("FAIL reset_regs got=%h exp=0",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm});
        end
        checks++;
        if (stall !== 1'b0 || stall_cnt !== 16'd0 || b_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_stall got=%b/%h/%h exp=0/0/0",
                     stall, stall_cnt, b_cnt);
        end
        rst = 1'b0;
        sb.push_back('{ADD, 32'd5, 32'd3, 32'h5020});
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL release_stall got=%b exp=0", stall);
        end
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL release_load got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
    endtask

    task automatic test_immediate();
        IF_instruction = ADDI;
        sb.push_back('{ADDI, 32'd0, 32'd0, 32'hFFFFFFFF});
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL imm_stall got=%b exp=0", stall);
        end
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL imm_load got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
    endtask

    task automatic test_load_use();
        s0 = 32'h100;
        IF_instruction = LW;
        sb.push_back('{LW, 32'h100, 32'd5, 32'd4});
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL lw_load got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
        IF_instruction = ADD;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL lu_ex_stall got=%b exp=1", stall);
        end
        sb.push_back('0);
        @(posedge clk); #1;
        exp_cnt++;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL lu_bubble1 got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
        MEM_instruction = LW;
        #1;
`ifdef ID_OPERAND_FETCH_FWD_EN
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL lu_fwd_stall got=%b exp=0", stall);
        end
        sb.push_back('{ADD, 32'hDEAD0001, 32'd3, 32'h5020});
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL lu_fwd_load got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
        MEM_instruction = '0;
`else
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL lu_mem_stall got=%b exp=1", stall);
        end
        sb.push_back('0);
        @(posedge clk); #1;
        exp_cnt++;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL lu_bubble2 got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
        checks++;
        if (stall_cnt !== 16'd2) begin
            failures++;
            $display("FAIL lu_cnt got=%0d exp=2", stall_cnt);
        end
        MEM_instruction = '0; t0 = 32'd7;
        sb.push_back('{ADD, 32'd7, 32'd3, 32'h5020});
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL lu_wb_stall got=%b exp=0", stall);
        end
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL lu_wb_load got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
`endif
    endtask

    task automatic test_forwarding();
        IF_instruction = '0;
        sb.push_back('0);
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL nop_load got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
        MEM_instruction = LW; MEM_result = 32'h12345678;
        IF_instruction = ADD;
        #1;
`ifdef ID_OPERAND_FETCH_FWD_EN
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL fwd_stall got=%b exp=0", stall);
        end
        sb.push_back('{ADD, 32'h12345678, 32'd3, 32'h5020});
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL fwd_rs got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
        IF_instruction = ADDD;
        sb.push_back('{ADDD, 32'h12345678, 32'h12345678, 32'h5020});
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL fwd_both got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
`else
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL mem_stall got=%b exp=1", stall);
        end
        sb.push_back('0);
        @(posedge clk); #1;
        exp_cnt++;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL mem_bubble got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
`endif
        MEM_instruction = '0; MEM_result = 32'hDEAD0001;
    endtask

    task automatic test_unmapped();
        t0 = 32'd7;
        IF_instruction = ADD7;
        sb.push_back('{ADD7, 32'd7, 32'd3, 32'h3820});
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL add7_load got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
        IF_instruction = USE7;
        sb.push_back('{USE7, 32'd0, 32'd3, 32'h5820});
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL unmapped_stall got=%b exp=0", stall);
        end
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL unmapped_load got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
    endtask

    task automatic test_flush();
        IF_instruction = ADD;
        sb.push_back('{ADD, 32'd7, 32'd3, 32'h5020});
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL fl_add got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
        t2 = 32'h22;
        IF_instruction = SW;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL rt_hazard got=%b exp=1", stall);
        end
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall got=%b exp=0", stall);
        end
        sb.push_back('0);
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL flush_bubble got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
        checks++;
        if (stall_cnt !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL flush_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
        end
        flush = 1'b0;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            IF_instruction = ADD;
            sb.push_back('{ADD, 32'd7, 32'd3, 32'h5020});
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
                failures++;
                $display("FAIL sat_add%0d got=%h exp=%h", i,
                         {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
            end
            IF_instruction = SW;
            #1;
            checks++;
            if (stall !== 1'b1) begin
                failures++;
                $display("FAIL sat_stall%0d got=%b exp=1", i, stall);
            end
            sb.push_back('0);
            @(posedge clk); #1;
            exp_cnt++;
            e = sb.pop_front(); checks++;
            if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
                failures++;
                $display("FAIL sat_bub%0d got=%h exp=%h", i,
                         {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
            end
        end
        checks++;
        if (stall_cnt !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL cnt16 got=%0d exp=%0d", stall_cnt, exp_cnt);
        end
        checks++;
        if (b_cnt !== 4'hF) begin
            failures++;
            $display("FAIL cnt4_sat got=%h exp=f", b_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        IF_instruction = ADD;
        sb.push_back('{ADD, 32'd7, 32'd3, 32'h5020});
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL rm_add got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
        IF_instruction = SW;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL rm_pre_stall got=%b exp=1", stall);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || stall_cnt !== 16'd0 || b_cnt !== 4'd0) begin
            failures++;
            $display("FAIL rm_reset got=%b/%h/%h exp=0/0/0",
                     stall, stall_cnt, b_cnt);
        end
        checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== '0) begin
            failures++;
            $display("FAIL rm_regs got=%h exp=0",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm});
        end
        exp_cnt = 0;
        rst = 1'b0;
        sb.push_back('{SW, 32'h100, 32'h22, 32'd0});
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL rm_post_stall got=%b exp=0", stall);
        end
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({ID_instruction, ID_rs_val, ID_rt_val, ID_imm} !== e) begin
            failures++;
            $display("FAIL rm_load got=%h exp=%h",
                     {ID_instruction, ID_rs_val, ID_rt_val, ID_imm}, e);
        end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_load_use();
        test_forwarding();
        test_unmapped();
        test_flush();
        test_saturation();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_operand_fetch.md
Name: id_operand_fetch

Overview:
- Instruction-decode / operand-read stage of the 5-stage MIPS pipeline; the read side of the architectural register set (t0-t5, s0-s5) that the writeback stage updates.
- Decodes the fetched instruction, reads rs/rt operands, sign-extends the immediate and registers everything into the ID/EX pipeline register.
- Detects RAW hazards against the instructions in the ID/EX and MEM stages, then stalls fetch and inserts bubbles.
- Keeps a saturating stall counter for performance measurement.

Parameters:
- CNT_W, 16, width of the stall_cnt performance counter.

Ports:
- clk  input  1  pipeline clock; ID/EX register and counter update on posedge.
- rst  input  1  asynchronous, active-high reset.
- IF_instruction  input  32  instruction from fetch stage.
- flush  input  1  discard current IF_instruction; load a bubble.
- MEM_instruction  input  32  instruction currently in MEM stage.
- MEM_result  input  32  value MEM stage will write back; used only with FWD_EN.
- t0,t1,t2,t3,t4,t5,s0,s1,s2,s3,s4,s5  input  32 each  architectural registers, written by writeback on negedge clk.
- ID_instruction  output  32  registered instruction for EX.
- ID_rs_val  output  32  registered rs operand.
- ID_rt_val  output  32  registered rt operand.
- ID_imm  output  32  registered sign-extended instr[15:0].
- stall  output  1  combinational; hold PC/IF when 1.
- stall_cnt  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Register map (5-bit index):
  - 8-13 -> t0-t5; 16-21 -> s0-s5; 0 -> zero.
  - Any other index reads 0 and is never a hazard target.
- Source use:
  - rs [25:21] is used by opcodes 000000, 100011, 001000, 101011, 000100.
  - rt [20:16] is used by 000000, 101011, 000100.
- Destination of a stage instruction:
  - Opcode 000000 -> rd [15:11].
  - 100011 / 001000 -> rt [20:16].
  - Otherwise none.
  - Destination 0 is never a hazard.
- hazard_ex: a used source of IF_instruction equals the destination of ID_instruction.
- hazard_mem: a used source equals the destination of MEM_instruction.
- Stall condition:
  - stall = !rst && !flush && (hazard_ex || hazard_mem). Without FWD_EN, see Optional Feature.
  - Priority: hazard_ex is checked before hazard_mem.
- Posedge clk:
  - If flush or stall: load a bubble (ID_instruction, ID_rs_val, ID_rt_val, ID_imm all 32'd0).
  - Otherwise: load IF_instruction, the operand reads (or forwarded values) and {{16{instr[15]}}, instr[15:0]}.
- Latency: 1 cycle IF -> ID outputs.
- WB-stage producers need no stall. Writeback writes on negedge, so the value is stable before the following posedge.
- flush together with a hazard: bubble is loaded, stall = 0.
- stall_cnt:
  - Increments on every posedge where stall = 1.
  - Saturates at all-ones and never wraps.
- Reset (asynchronous):
  - All registered outputs and stall_cnt go to 0; stall = 0 while rst = 1.
  - Reset mid-stall drops the stall immediately.
  - After reset release, the first posedge loads IF_instruction normally.

Optional Feature:
- Macro: ID_OPERAND_FETCH_FWD_EN.
- Defined:
  - hazard_mem never stalls. The matching operand takes MEM_result instead.
  - If rs and rt both match, both take MEM_result.
  - hazard_ex still stalls.
- Undefined:
  - MEM_result is ignored.
  - stall = !rst && !flush && (hazard_ex || hazard_mem).

Test Plan:
- Reset: rst=1 with IF_instruction=0x01095020, t0=5 -> all outputs 0 and stall=0. Release, then one posedge -> ID_instruction=0x01095020, ID_rs_val=5.
- Immediate: IF=0x2011FFFF (addi $s1,$zero,-1), no hazards -> ID_rs_val=0, ID_imm=0xFFFFFFFF, stall=0.
- Load-use:
  - ID_instruction=0x8E080004 (lw $t0,4($s0)), IF=0x01095020 (add $t2,$t0,$t1) -> stall=1, bubble on next posedge.
  - Next cycle, with MEM_instruction=0x8E080004 and no FWD: stall=1 again, stall_cnt=2.
  - Third cycle, WB has written t0=7 -> ID_rs_val=7.
- Forwarding (FWD_EN): MEM_instruction=0x8E080004, MEM_result=0x12345678, IF=0x01095020, ID_instruction=0 -> stall=0, ID_rs_val=0x12345678.
- Flush priority: hazard_ex active and flush=1 -> stall=0, bubble loaded, stall_cnt unchanged.
- Saturation: CNT_W=4, hold a hazard for 20 cycles -> stall_cnt sticks at 4'hF.
